// File: rtl/aes_128_stream_ctrl.sv
// Stream feeder/collector for a pipelined aes_128 core without stall:
// packs 32-bit words into blocks, launches on credit, buffers results.
module aes_128_stream_ctrl #(
  parameter int CORE_LATENCY = 21,
  parameter int OUT_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [127:0] key_in,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(OUT_DEPTH);

  logic [2:0]            wcnt;
  logic [31:0]           words [4];
  logic [CORE_LATENCY:0] vpipe;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [127:0]          mem [OUT_DEPTH];
  logic [CW:0]           used;
  logic                  launch;
  logic                  accept;
  logic                  retire;
  logic                  pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Credits: every launched block already owns a FIFO slot.
  assign used      = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign launch    = (wcnt == 3'd4) && (used < DEPTH_C);
  assign in_ready  = rst_n & ((wcnt != 3'd4) | launch);
  assign accept    = in_valid & in_ready;
  assign retire    = vpipe[CORE_LATENCY];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rptr];
  assign busy      = (wcnt != 3'd0) | (inflight != '0) | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= 3'd0;
      words      <= '{default: '0};
      vpipe      <= '0;
      inflight   <= '0;
      fifo_cnt   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      mem        <= '{default: '0};
      core_state <= '0;
      core_key   <= '0;
    end else begin
      if (launch)
        wcnt <= accept ? 3'd1 : 3'd0;
      else if (accept)
        wcnt <= wcnt + 3'd1;

      if (accept)
        words[launch ? 2'd0 : wcnt[1:0]] <= in_data;

      if (launch) begin
        core_state <= {words[0], words[1], words[2], words[3]};
        core_key   <= key_in;
      end

      vpipe    <= {vpipe[CORE_LATENCY-1:0], launch};
      inflight <= inflight + CW'(launch) - CW'(retire);

      if (retire) begin
        mem[wptr] <= core_out;
        wptr      <= nxt(wptr);
      end
      if (pop)
        rptr <= nxt(rptr);
      fifo_cnt <= fifo_cnt + CW'(retire) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      assert (!(retire && fifo_cnt == CW'(OUT_DEPTH)));
  end

endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// Bench for aes_128_stream_ctrl: latency-21 core model with a
// known-vector table, scoreboard queue of expected ciphertexts.
module tb_aes_128_stream_ctrl;

  localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffeedface;
  localparam logic [127:0] K4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] K5 = 128'h55aa55aa00ff00ff1234567887654321;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [127:0] key_in = '0;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_out = 0;
  int launches = 0;
  int last_launch = 0;
  int rise_edge = -1;
  logic prev_ov = 1'b0;
  logic [127:0] prev_cs = '0;
  logic [127:0] prev_ck = '0;
  logic [127:0] exp_q [$];
  int out_edge [$];
  logic [127:0] cp [21];

  aes_128_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .key_in     (key_in),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] aes_ref(input logic [127:0] s,
                                           input logic [127:0] k);
    if (s == V1 && k == K1) return C1;
    if (s == V2 && k == K2) return C2;
    if (s == '0 && k == '0) return C0;
    return s ^ {k[63:0], k[127:64]} ^ {4{32'h5a3c_96e1}};
  endfunction

  function automatic logic [127:0] blkv(input int b);
    logic [31:0] w;
    w = 32'(b) * 32'h0101_0101 + 32'h1000_0003;
    return {w, w ^ 32'hffff_0000, w + 32'd7, ~w};
  endfunction

  // Core model: 21 register stages, no valid
  always @(posedge clk) begin
    cp[0] <= aes_ref(core_state, core_key);
    for (int i = 1; i < 21; i++) cp[i] <= cp[i-1];
  end
  assign core_out = cp[20];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) rise_edge = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("extra_out", {127'b0, out_valid}, 128'd0);
        else
          chk("out_data", out_data, exp_q.pop_front());
        n_out++;
        out_edge.push_back(cyc);
      end
      if (core_state != prev_cs || core_key != prev_ck) begin
        launches++;
        last_launch = cyc;
      end
    end
    prev_ov = out_valid;
    prev_cs = core_state;
    prev_ck = core_key;
  end

  task automatic put_word(input logic [31:0] w, output int a);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_wait", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    a = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk,
                            input logic [127:0] key,
                            input logic [127:0] expv,
                            output int a);
    int t;
    put_word(blk[127:96], t);
    key_in = key;
    put_word(blk[95:64], t);
    put_word(blk[63:32], t);
    put_word(blk[31:0], a);
    exp_q.push_back(expv);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t, n0, l0, l4, n, cnt;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_core_state", core_state, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

    // 1: single block, latency
    out_ready = 1'b1;
    rise_edge = -1;
    send_block(V1, K1, C1, a);
    chk("t1_busy", {127'b0, busy}, 128'd1);
    n = 0;
    while (rise_edge < 0 && n < 40) begin
      wait_cycles(1);
      n++;
    end
    chk("t1_latency", 128'(rise_edge - a), 128'd23);
    wait_drain(50);

    // 2: three back-to-back blocks
    out_edge.delete();
    send_block(V2, K2, C2, t);
    send_block(V1, K1, C1, t);
    send_block('0, '0, C0, t);
    wait_drain(60);
    chk("t2_count", 128'(out_edge.size()), 128'd3);
    if (out_edge.size() == 3) begin
      chk("t2_gap1", 128'(out_edge[1] - out_edge[0]), 128'd4);
      chk("t2_gap2", 128'(out_edge[2] - out_edge[1]), 128'd4);
    end

    // 3: backpressure, 6 blocks
    out_ready = 1'b0;
    key_in = K3;
    l0 = launches;
    n0 = n_out;
    fork
      begin
        for (int b = 0; b < 6; b++)
          send_block(blkv(b), K3, aes_ref(blkv(b), K3), t);
      end
      begin
        wait_cycles(60);
        chk("t3_launches", 128'(launches - l0), 128'd4);
        chk("t3_in_ready", {127'b0, in_ready}, 128'd0);
        chk("t3_out_valid", {127'b0, out_valid}, 128'd1);
        out_ready = 1'b1;
      end
    join
    wait_drain(200);
    chk("t3_outputs", 128'(n_out - n0), 128'd6);

    // 4: pop and write on the same edge, credit timing
    out_ready = 1'b0;
    l0 = launches;
    n0 = n_out;
    for (int b = 10; b < 15; b++)
      send_block(blkv(b), K4, aes_ref(blkv(b), K4), t);
    wait_cycles(2);
    chk("t4_launches", 128'(launches - l0), 128'd4);
    l4 = last_launch;
    n = 0;
    while (cyc < l4 + 21 && n < 40) begin
      wait_cycles(1);
      n++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_no_same_edge_credit", {127'b0, in_ready}, 128'd0);
    @(negedge clk);
    chk("t4_credit_next_edge", {127'b0, in_ready}, 128'd1);
    chk("t4_valid_a", {127'b0, out_valid}, 128'd1);
    @(negedge clk);
    chk("t4_valid_b", {127'b0, out_valid}, 128'd1);
    wait_drain(200);
    chk("t4_outputs", 128'(n_out - n0), 128'd5);

    // 5: reset with 2 in flight, 1 stored
    out_ready = 1'b0;
    for (int b = 20; b < 23; b++)
      send_block(blkv(b), K5, aes_ref(blkv(b), K5), t);
    n = 0;
    while (!out_valid && n < 60) begin
      wait_cycles(1);
      n++;
    end
    chk("t5_stored", {127'b0, out_valid}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", {127'b0, out_valid}, 128'd0);
    chk("t5_in_ready", {127'b0, in_ready}, 128'd0);
    chk("t5_busy", {127'b0, busy}, 128'd0);
    exp_q.delete();
    #20 rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("t5_no_stale", 128'(cnt), 128'd0);

    // 6: partial block, key sampled at launch
    @(posedge clk);
    #1;
    key_in = K1;
    put_word(V1[127:96], t);
    put_word(V1[95:64], t);
    wait_cycles(10);
    chk("t6_no_launch", core_state, 128'd0);
    chk("t6_busy", {127'b0, busy}, 128'd1);
    chk("t6_in_ready", {127'b0, in_ready}, 128'd1);
    put_word(V1[63:32], t);
    put_word(V1[31:0], a);
    exp_q.push_back(C1);
    @(posedge clk);
    #1;
    key_in = ~K1;
    chk("t6_core_key", core_key, K1);
    chk("t6_core_state", core_state, V1);
    wait_drain(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
